// File: rtl/he_pkg.sv
// Shared types for the homomorphic-encryption datapath.
// Coefficient/tile typedefs, FSM encoding and default modulus.
package he_pkg;

    localparam int HE_DATA_WIDTH = 64;
    localparam int HE_TILE_WIDTH = 8;

    localparam logic [63:0] DEFAULT_MODULUS = 64'hFFFF_FFFF_0000_0001;

    typedef logic [HE_DATA_WIDTH-1:0] coeff_t;
    typedef coeff_t [HE_TILE_WIDTH-1:0] tile_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC_C0 = 2'd1,
        ST_ACC_C1 = 2'd2,
        ST_DONE   = 2'd3
    } relin_acc_state_e;

endpackage

// File: rtl/relin_accumulator_if.sv
// Tile streams and control lines of the relin accumulator.
// master = environment side, slave = accumulator side.
interface relin_acc_if
    import he_pkg::*;
#(
    parameter int DW = HE_DATA_WIDTH,
    parameter int TW = HE_TILE_WIDTH,
    parameter int IW = 3
);
    logic                   start;
    logic                   c1_or_c0;
    logic                   relin_valid;
    logic [TW-1:0][DW-1:0]  relin_tile;
    logic                   base_valid;
    logic                   base_ready;
    logic [TW-1:0][DW-1:0]  base_tile;
    logic                   out_valid;
    logic                   out_ready;
    logic [TW-1:0][DW-1:0]  out_tile;
    logic [IW-1:0]          out_index;
    logic                   out_poly;
    logic                   done;
    logic                   overflow;

    modport master (
        output start, relin_valid, relin_tile,
        output base_valid, base_tile, out_ready,
        input  c1_or_c0, base_ready, out_valid,
        input  out_tile, out_index, out_poly,
        input  done, overflow
    );

    modport slave (
        input  start, relin_valid, relin_tile,
        input  base_valid, base_tile, out_ready,
        output c1_or_c0, base_ready, out_valid,
        output out_tile, out_index, out_poly,
        output done, overflow
    );

endinterface

// File: rtl/relin_accumulator_tile_fifo.sv
// tile_fifo: small power-of-two FIFO for whole tiles.
// A push while full is dropped unless a pop happens in the same cycle.
module tile_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage needs no reset; only the pointers define contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointer bookkeeping with an extra wrap bit for full/empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/relin_accumulator.sv
// relin_accumulator: adds buffered relin tiles onto c0 then c1 tiles.
// Define RELIN_ACC_MOD_REDUCE_EN for modular instead of wraparound add.
module relin_accumulator
    import he_pkg::*;
#(
    parameter int DATA_WIDTH       = HE_DATA_WIDTH,
    parameter int TILE_WIDTH       = HE_TILE_WIDTH,
    parameter int POLY_LENGTH      = 64,
    parameter int RELIN_FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] MODULUS =
        DATA_WIDTH'(DEFAULT_MODULUS)
) (
    input logic  clk,
    input logic  rst,
    relin_acc_if.slave bus
);
    localparam int TPP = POLY_LENGTH / TILE_WIDTH;
    localparam int IW  = (TPP > 1) ? $clog2(TPP) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(TPP - 1);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_C0   = ST_ACC_C0;
    localparam logic [1:0] S_C1   = ST_ACC_C1;
    localparam logic [1:0] S_DONE = ST_DONE;

    typedef logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] tile_w_t;

    if ((POLY_LENGTH % TILE_WIDTH) != 0 || RELIN_FIFO_DEPTH < 2 ||
        (RELIN_FIFO_DEPTH & (RELIN_FIFO_DEPTH - 1)) != 0 ||
        MODULUS == '0) begin : g_bad_cfg
        $error("relin_accumulator: invalid configuration");
    end

    logic [1:0]    state;
    logic [IW-1:0] cnt;
    logic          busy;
    logic          start_acc;
    logic          join_fire;
    logic          ovf_evt;
    logic          fifo_full;
    logic          fifo_empty;
    tile_w_t       relin_head;
    tile_w_t       sum_tile;
    logic          out_valid_q;
    tile_w_t       out_tile_q;
    logic [IW-1:0] out_index_q;
    logic          out_poly_q;
    logic          overflow_q;

    function automatic logic [DATA_WIDTH-1:0] coeff_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
`ifdef RELIN_ACC_MOD_REDUCE_EN
        logic [DATA_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, MODULUS}) s = s - {1'b0, MODULUS};
        return s[DATA_WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    tile_fifo #(
        .DEPTH (RELIN_FIFO_DEPTH),
        .WIDTH (TILE_WIDTH * DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (bus.relin_valid),
        .pop   (join_fire),
        .din   (bus.relin_tile),
        .dout  (relin_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign busy      = (state == S_C0) || (state == S_C1);
    assign start_acc = bus.start && ((state == S_IDLE) || (state == S_DONE));
    assign join_fire = busy && !fifo_empty && bus.base_valid &&
                       (!out_valid_q || bus.out_ready);
    assign ovf_evt   = bus.relin_valid && fifo_full && !join_fire;

    assign bus.base_ready = join_fire;
    assign bus.c1_or_c0   = (state == S_C1);
    assign bus.done       = (state == S_DONE);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_tile   = out_tile_q;
    assign bus.out_index  = out_index_q;
    assign bus.out_poly   = out_poly_q;
    assign bus.overflow   = overflow_q;

    // Coefficient-wise sum of the ciphertext tile and the relin head.
    always_comb begin
        sum_tile = '0;
        for (int i = 0; i < TILE_WIDTH; i++) begin
            sum_tile[i] = coeff_add(bus.base_tile[i], relin_head[i]);
        end
    end

    // Polynomial sequencing: c0 tiles, then c1 tiles, then done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (start_acc) begin
            state <= S_C0;
            cnt   <= '0;
        end else if (join_fire) begin
            if (cnt == LAST_IDX) begin
                cnt <= '0;
                unique case (state)
                    S_C0:    state <= S_C1;
                    default: state <= S_DONE;
                endcase
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Sticky drop flag, cleared when a new ciphertext begins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) overflow_q <= 1'b0;
        else      overflow_q <= (overflow_q && !start_acc) || ovf_evt;
    end

    // Output register: loads on join, holds until taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_tile_q  <= '0;
            out_index_q <= '0;
            out_poly_q  <= 1'b0;
        end else if (join_fire) begin
            out_valid_q <= 1'b1;
            out_tile_q  <= sum_tile;
            out_index_q <= cnt;
            out_poly_q  <= (state == S_C1);
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: doc/relin_accumulator.md
Name: relin_accumulator

Overview:
- Downstream stage of the relinearisation unit.
- Consumes each summed relin output tile and adds it coefficient-wise to the matching c0 or c1 ciphertext tile, producing the final relinearised ciphertext tile stream.
- Buffers relin tiles because the relin adder trees cannot be back-pressured.
- Sequences c0 then c1 and drives the c1_or_c0 select back to the relin unit.

Parameters:
- DATA_WIDTH, 64, coefficient width in bits.
- TILE_WIDTH, 8, coefficients per tile; equals the relin unit's C2 tile width.
- POLY_LENGTH, 64, coefficients per polynomial; must be a multiple of TILE_WIDTH.
- RELIN_FIFO_DEPTH, 4, relin tile buffer depth; power of two, at least 2.
- MODULUS, 64'hFFFF_FFFF_0000_0001, ciphertext modulus; used only with MOD_REDUCE_EN.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle pulse that begins one ciphertext (c0 then c1); ignored unless in IDLE or DONE.
- c1_or_c0, out, 1, polynomial select to the relin unit: 0 = c0, 1 = c1.
- relin_valid, in, 1, one-cycle strobe that a relin tile is present; no ready.
- relin_tile, in, TILE_WIDTH x DATA_WIDTH, summed relin tile.
- base_valid, in, 1, ciphertext tile valid.
- base_ready, out, 1, ciphertext tile accepted this cycle.
- base_tile, in, TILE_WIDTH x DATA_WIDTH, c0/c1 tile in index order.
- out_valid, out, 1, result tile valid.
- out_ready, in, 1, downstream accepts.
- out_tile, out, TILE_WIDTH x DATA_WIDTH, result tile.
- out_index, out, clog2(POLY_LENGTH/TILE_WIDTH), tile index of out_tile.
- out_poly, out, 1, 0 = c0, 1 = c1, for out_tile.
- done, out, 1, high in DONE state.
- overflow, out, 1, sticky; relin tile arrived while the FIFO was full.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, FIFO empty, counters 0. All outputs 0: c1_or_c0, base_ready, out_valid, out_tile, out_index, out_poly, done, overflow.
- FSM states: IDLE, ACC_C0, ACC_C1, DONE.
  - IDLE or DONE, start=1 -> ACC_C0. Tile counter clears, overflow clears, done goes 0.
  - ACC_C0 -> ACC_C1 when the join fires on tile TPP-1 (TPP = POLY_LENGTH/TILE_WIDTH). Counter wraps to 0.
  - ACC_C1 -> DONE when the join fires on tile TPP-1.
  - done = 1 only in DONE.
  - c1_or_c0 = 1 in ACC_C1; 0 in all other states.
- FIFO:
  - relin_valid writes relin_tile every cycle it is high, regardless of state.
  - Write while full: tile dropped, overflow set to 1.
  - Simultaneous write and pop while full: both occur; no overflow.
- Join fires when all hold: state is ACC_C0 or ACC_C1, FIFO not empty, base_valid=1, and the output register is empty or out_ready=1.
  - base_ready = join, combinational.
  - On join: FIFO pops; output register loads base + relin coefficient-wise; out_index = counter; out_poly = current poly.
- Latency: result appears one cycle after the join. out_valid stays high and out_tile stable until out_ready.
- Full throughput: one tile per cycle when out_ready is held high.
- Arithmetic, default: each coefficient is (base + relin) mod 2^DATA_WIDTH; carry discarded.
- start during ACC_C0 or ACC_C1: ignored.
- Relin tiles still in the FIFO on entering DONE stay there and are consumed by the next start.
- Reset mid-operation: everything returns to reset values; in-flight tiles are lost.

Optional Feature:
- Macro: RELIN_ACC_MOD_REDUCE_EN.
- Defined: each coefficient = s - MODULUS if s >= MODULUS, else s, where s is the DATA_WIDTH+1-bit sum. Both operands must be < MODULUS. Latency is unchanged.
- Undefined: wraparound add as above; MODULUS unused.

Decomposition:
- Shared package (he_pkg):
  - typedef coeff_t (DATA_WIDTH logic).
  - typedef for the tile array.
  - enum relin_acc_state_e.
  - localparam DEFAULT_MODULUS.
- One sub-module, tile_fifo: parameterised on depth and payload width; provides full, empty, push, pop. Reusable for the polymult output queue.

Test Plan:
- Reset and idle: hold rst low with relin_valid=1 -> all outputs 0. After release with no start, base_ready stays 0.
- Basic sum: start; POLY_LENGTH=16, TILE_WIDTH=8, so 2 tiles per poly. Relin tiles all 5, base tiles all 3, out_ready=1 -> four tiles, all coefficients 8.
  - Sequence: out_poly/out_index = 0/0, 0/1, 1/0, 1/1.
  - c1_or_c0 rises after the second join.
  - done = 1 one cycle after the fourth join.
- Wraparound: base 64'hFFFF_FFFF_FFFF_FFFF, relin 2 -> result 1.
  - With RELIN_ACC_MOD_REDUCE_EN, base MODULUS-1 and relin 3 -> result 2.
- Backpressure: out_ready=0 for 5 cycles with valid inputs -> out_tile held stable, base_ready=0, FIFO retains tiles. Resume -> order preserved, no loss.
- Overflow: depth 4, 5 relin strobes with base_valid=0 -> overflow=1 and the fifth tile dropped. Next start clears overflow.
- Async reset while ACC_C1 holds tile 1 in the output register -> out_valid and c1_or_c0 drop immediately; state IDLE.
